// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM states, operand mode encoding and step-counter sizing.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Counter must hold WIDTH+1 (the number of Booth steps).
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {acc, q, q_1}.
module booth_step #(
    parameter int N = 9
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] m,
    input  logic [N-1:0] q,
    input  logic         q_1,
    output logic [N-1:0] acc_next,
    output logic [N-1:0] q_next,
    output logic         q_1_next
);

    logic [N-1:0] sum_s;

    // Booth recoding on {q[0], q_1}, then the one-bit arithmetic shift.
    always_comb begin
        sum_s = acc;
        case ({q[0], q_1})
            2'b01:   sum_s = acc + m;
            2'b10:   sum_s = acc + ~m + N'(1);
            default: sum_s = acc;
        endcase
        acc_next = {sum_s[N-1], sum_s[N-1:1]};
        q_next   = {sum_s[0], q[N-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed or unsigned WIDTH x WIDTH product,
// one step per clock, start/busy/done handshake with a held result register.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int XW = WIDTH + 1;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t             state_r, state_next_s;
    logic [XW-1:0]      acc_r, acc_next_s;
    logic [XW-1:0]      m_r, m_next_s;
    logic [XW-1:0]      q_r, q_next_s;
    logic               q1_r, q1_next_s;
    logic [CW-1:0]      count_r, count_next_s;
    logic [2*WIDTH-1:0] out_r, out_next_s;
    logic               busy_r, done_r;

    logic [XW-1:0]      step_acc_s, step_q_s;
    logic               step_q1_s;
    logic [2*XW-1:0]    prod_s;
    logic               a_ext_s, b_ext_s;

    assign a_ext_s = (signed_mode == MODE_SIGNED) ? a[WIDTH-1] : 1'b0;
    assign b_ext_s = (signed_mode == MODE_SIGNED) ? b[WIDTH-1] : 1'b0;
    assign prod_s  = {step_acc_s, step_q_s};

    booth_step #(
        .N(XW)
    ) u_step (
        .acc      (acc_r),
        .m        (m_r),
        .q        (q_r),
        .q_1      (q1_r),
        .acc_next (step_acc_s),
        .q_next   (step_q_s),
        .q_1_next (step_q1_s)
    );

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        m_next_s     = m_r;
        q_next_s     = q_r;
        q1_next_s    = q1_r;
        count_next_s = count_r;
        out_next_s   = out_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    m_next_s     = {a_ext_s, a};
                    q_next_s     = {b_ext_s, b};
                    acc_next_s   = {XW{1'b0}};
                    q1_next_s    = 1'b0;
                    count_next_s = {CW{1'b0}};
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                acc_next_s   = step_acc_s;
                q_next_s     = step_q_s;
                q1_next_s    = step_q1_s;
                count_next_s = count_r + CW'(1);
                // The last step's result goes straight into out on the same edge.
                if (count_r == CNT_LAST) begin
                    out_next_s   = prod_s[2*WIDTH-1:0];
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= {XW{1'b0}};
            m_r     <= {XW{1'b0}};
            q_r     <= {XW{1'b0}};
            q1_r    <= 1'b0;
            count_r <= {CW{1'b0}};
            out_r   <= {(2*WIDTH){1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            acc_r   <= acc_next_s;
            m_r     <= m_next_s;
            q_r     <= q_next_s;
            q1_r    <= q1_next_s;
            count_r <= count_next_s;
            out_r   <= out_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier at WIDTH=8 and WIDTH=16: a latency/
// arithmetic reference model checked every cycle, plus hand-computed products.
module tb_booth_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] out8;
    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] out16;

    booth_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .out(out8)
    );

    booth_multiplier #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .out(out16)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic: plain integer product, truncated to 2*w bits.
    function automatic longint mul(input int w, input bit sm, input longint x, input longint y);
        longint xs, ys, mask;
        xs = x;
        ys = y;
        mask = (longint'(1) << (2 * w)) - 1;
        if (sm && xs[w-1]) xs = xs - (longint'(1) << w);
        if (sm && ys[w-1]) ys = ys - (longint'(1) << w);
        return (xs * ys) & mask;
    endfunction

    // Model: accept start when not busy, finish WIDTH+1 edges later.
    bit     mb[2];
    bit     md[2];
    longint mo[2];
    longint mp[2];
    int     mrem[2];

    task automatic mstep(input int k, input bit st, input bit sm, input longint x,
                         input longint y, input int w);
        if (mb[k]) begin
            mrem[k]--;
            if (mrem[k] == 0) begin
                mb[k] = 1'b0;
                md[k] = 1'b1;
                mo[k] = mp[k];
            end
        end else begin
            md[k] = 1'b0;
            if (st) begin
                mb[k]   = 1'b1;
                mrem[k] = w + 1;
                mp[k]   = mul(w, sm, x, y);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mb[i] = 1'b0; md[i] = 1'b0; mo[i] = 0; mp[i] = 0; mrem[i] = 0;
            end
        end else begin
            mstep(0, start8, sm8, longint'(a8), longint'(b8), 8);
            mstep(1, start16, sm16, longint'(a16), longint'(b16), 16);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy8", longint'(busy8), longint'(mb[0]));
            chk("done8", longint'(done8), longint'(md[0]));
            chk("out8", longint'(out8), mo[0]);
            chk("busy16", longint'(busy16), longint'(mb[1]));
            chk("done16", longint'(done16), longint'(md[1]));
            chk("out16", longint'(out16), mo[1]);
            chk("busy_done_excl8", longint'(busy8 & done8), 0);
        end
    end

    // Wait for done8 with a cycle bound; returns number of edges since the accept edge.
    task automatic wait_done8(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 40);
    endtask

    task automatic wait_done16(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done16 && n < 60);
    endtask

    task automatic run8(input string name, input bit sm, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp);
        int n;
        start8 = 1'b1; sm8 = sm; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; sm8 = ~sm; a8 = 8'h5A; b8 = 8'hC3;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 10);
        chk(name, longint'(out8), longint'(exp));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int pulses;
        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; sm16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        #2;
        chk("rst_busy", longint'(busy8), 0);
        chk("rst_done", longint'(done8), 0);
        chk("rst_out", longint'(out8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("s_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001);
        run8("s_ff_01", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
        run8("u_00_ab", 1'b0, 8'h00, 8'hAB, 16'h0000);
        run8("s_7f_80", 1'b1, 8'h7F, 8'h80, 16'hC080);

        // Start pulsed mid-RUN must be ignored.
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h02; b8 = 8'h03;
        @(negedge clk);
        start8 = 1'b0;
        n = 4;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_latency", n, 10);
        chk("ignore_out", longint'(out8), 64'h4000);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("ignore_single_done", pulses, 0);

        // Asynchronous reset mid-RUN.
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", longint'(busy8), 0);
        chk("abort_done", longint'(done8), 0);
        chk("abort_out", longint'(out8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        run8("after_abort", 1'b0, 8'h12, 8'h34, 16'h03A8);

        // WIDTH=16, start held high through DONE for two operations.
        start16 = 1'b1; sm16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
        wait_done16(n);
        chk("w16_first_latency", n, 18);
        chk("w16_first_out", longint'(out16), 64'h06260060);
        sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h7FFF;
        wait_done16(n);
        start16 = 1'b0;
        chk("w16_second_latency", n, 18);
        chk("w16_second_out", longint'(out16), 64'hC0008000);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("w16_hold_out", longint'(out16), 64'hC0008000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
